bomb_ctrl: RTL and testbench
============================

Name: bomb_ctrl

Overview:
Single-bomb controller that consumes a player module's bomb_drop request and position. It latches the bomb on the 32-px tile grid, runs a fuse timer, then publishes a cross-shaped blast as two axis-aligned hit boxes for the player modules' bomb collision inputs. It also drives the bomb/blast sprite selects for the color mapper. All timing is counted in frames on frame_clk.

Parameters:
TILE, 32, grid pitch in pixels (power of two)
TILE_SHIFT, 5, log2(TILE)
HALF_X, 10, player sprite half-width used for snapping
HALF_Y, 13, player sprite half-height used for snapping
RANGE, 2, blast arm length in tiles on each side of the bomb tile
FUSE_FRAMES, 120, frames from drop to detonation
BLAST_FRAMES, 30, frames the blast boxes stay live
COOLDOWN_FRAMES, 15, frames after blast before a new drop is accepted
X_MIN, 32, playfield left bound
X_MAX, 575, playfield right bound
Y_MIN, 32, playfield top bound
Y_MAX, 447, playfield bottom bound

Ports:
frame_clk  in  1  frame-rate clock, all state on rising edge
Reset  in  1  asynchronous, active-high reset
bomb_drop  in  1  drop request from the player module (level; may be held high)
userX  in  10  player sprite top-left X
userY  in  10  player sprite top-left Y
bombTileX  out  10  bomb tile top-left X (for the sprite)
bombTileY  out  10  bomb tile top-left Y
bomb_visible  out  1  high during FUSE
exploding  out  1  high during EXPLODE
hX, hY, hXS, hYS  out  10 each  horizontal blast arm: origin and extent (extent = width-1 / height-1)
vX, vY, vXS, vYS  out  10 each  vertical blast arm: origin and extent
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state): state=IDLE, all counters 0, every output 0, drop_prev=0. Zeroed boxes (origin 0, extent 0) never register as collisions because the collision check requires pos>origin and pos<=origin+extent.
- All outputs are registered.
- drop_prev <= bomb_drop every cycle. A drop edge is bomb_drop=1 && drop_prev=0. A held request fires only once.
- State IDLE, on a drop edge:
  - bombTileX <= ((userX+HALF_X)>>TILE_SHIFT)<<TILE_SHIFT.
  - bombTileY <= ((userY+HALF_Y)>>TILE_SHIFT)<<TILE_SHIFT.
  - cnt <= FUSE_FRAMES-1; state <= FUSE.
  - Sums are computed 11-bit, then truncated.
- State FUSE: bomb_visible=1. cnt decrements each cycle. On the cycle cnt==0, state <= EXPLODE and cnt <= BLAST_FRAMES-1, and the boxes are loaded on that same edge. FUSE therefore lasts exactly FUSE_FRAMES cycles.
- Box load, 11-bit signed intermediates, clamped to the playfield:
  - hX = max(bombTileX - RANGE*TILE, X_MIN).
  - hR = min(bombTileX + (RANGE+1)*TILE - 1, X_MAX).
  - hXS = hR - hX; hY = bombTileY; hYS = TILE-1.
  - vY = max(bombTileY - RANGE*TILE, Y_MIN).
  - vB = min(bombTileY + (RANGE+1)*TILE - 1, Y_MAX).
  - vYS = vB - vY; vX = bombTileX; vXS = TILE-1.
- State EXPLODE: exploding=1, bomb_visible=0, boxes held constant. On cnt==0, state <= COOLDOWN, cnt <= COOLDOWN_FRAMES-1, and all box outputs <= 0 on that edge. EXPLODE lasts BLAST_FRAMES cycles.
- State COOLDOWN: bombTileX/Y hold their value; sprite selects are low. On cnt==0, state <= IDLE.
- Drop edges in FUSE, EXPLODE or COOLDOWN are ignored and are not queued. A request still held high on return to IDLE does not fire; a fresh edge is required.
- busy = (state != IDLE).
- Reset asserted mid-FUSE or mid-EXPLODE aborts immediately: boxes go to 0 asynchronously, and there is no residual blast after release.
- A count parameter of 1 gives a one-cycle state. Count parameters must be at least 1.

Test Plan:
- Reset, then userX=100, userY=200, pulse bomb_drop for 1 cycle -> next edge: bombTileX=96, bombTileY=192, bomb_visible=1, busy=1. Exactly 120 cycles later exploding=1 with hX=32, hXS=159, hY=192, hYS=31, vX=96, vXS=31, vY=128, vYS=159.
- Clamp case: userX=540, userY=420 -> tile (544,416). Blast: hX=480, hXS=95, vY=352, vYS=95 (right and bottom ends clamped to 575/447).
- Hold bomb_drop=1 continuously for 200 cycles -> exactly one bomb. The blast lasts 30 cycles, then all boxes are 0. There is no second FUSE after COOLDOWN until bomb_drop falls and rises again.
- New drop edge at cycle 50 of FUSE and during COOLDOWN -> ignored. bombTileX/Y are unchanged and detonation timing is unaffected.
- Assert Reset at cycle 10 of EXPLODE -> all outputs 0 immediately (asynchronously). After release, state is IDLE and the next drop edge starts a fresh 120-frame fuse.
- Blast boxes against a player at (100,196) inside the horizontal arm -> pos>hX and pos<=hX+hXS hold. With a player at (300,196), no overlap is reported.

Source files
------------

// File: rtl/bomb_ctrl.sv
// Single-bomb controller: snaps a drop request to the tile grid, runs the fuse,
// then publishes a clamped cross-shaped blast as two hit boxes.
module bomb_ctrl #(
   parameter int TILE            = 32,
   parameter int TILE_SHIFT      = 5,
   parameter int HALF_X          = 10,
   parameter int HALF_Y          = 13,
   parameter int RANGE           = 2,
   parameter int FUSE_FRAMES     = 120,
   parameter int BLAST_FRAMES    = 30,
   parameter int COOLDOWN_FRAMES = 15,
   parameter int X_MIN           = 32,
   parameter int X_MAX           = 575,
   parameter int Y_MIN           = 32,
   parameter int Y_MAX           = 447
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       bomb_drop,
   input  logic [9:0] userX,
   input  logic [9:0] userY,
   output logic [9:0] bombTileX,
   output logic [9:0] bombTileY,
   output logic       bomb_visible,
   output logic       exploding,
   output logic [9:0] hX,
   output logic [9:0] hY,
   output logic [9:0] hXS,
   output logic [9:0] hYS,
   output logic [9:0] vX,
   output logic [9:0] vY,
   output logic [9:0] vXS,
   output logic [9:0] vYS,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, FUSE, EXPLODE, COOLDOWN} state_t;

   typedef struct packed {
      logic [9:0] h_x, h_y, h_xs, h_ys;
      logic [9:0] v_x, v_y, v_xs, v_ys;
   } box_t;

   localparam logic [15:0] FUSE_LD  = 16'(FUSE_FRAMES - 1);
   localparam logic [15:0] BLAST_LD = 16'(BLAST_FRAMES - 1);
   localparam logic [15:0] COOL_LD  = 16'(COOLDOWN_FRAMES - 1);

   localparam logic signed [10:0] ARM   = signed'(11'(RANGE * TILE));
   localparam logic signed [10:0] REACH = signed'(11'((RANGE + 1) * TILE - 1));
   localparam logic signed [10:0] XLO   = signed'(11'(X_MIN));
   localparam logic signed [10:0] XHI   = signed'(11'(X_MAX));
   localparam logic signed [10:0] YLO   = signed'(11'(Y_MIN));
   localparam logic signed [10:0] YHI   = signed'(11'(Y_MAX));
   localparam logic [9:0]         SPAN  = 10'(TILE - 1);

   state_t      state, state_n;
   logic [15:0] cnt, cnt_n;
   logic        drop_prev;
   logic [9:0]  tile_x_n, tile_y_n;
   box_t        box_q, box_n;

   logic [10:0]        sum_x, sum_y;
   logic [9:0]         snap_x, snap_y;
   logic signed [10:0] tx, ty;
   logic signed [10:0] h_lo_raw, h_hi_raw, v_lo_raw, v_hi_raw;
   logic signed [10:0] h_lo, h_hi, v_lo, v_hi;

   // Snap the sprite centre onto the tile grid (11-bit sum, truncated)
   assign sum_x  = {1'b0, userX} + 11'(HALF_X);
   assign sum_y  = {1'b0, userY} + 11'(HALF_Y);
   assign snap_x = 10'((sum_x >> TILE_SHIFT) << TILE_SHIFT);
   assign snap_y = 10'((sum_y >> TILE_SHIFT) << TILE_SHIFT);

   assign tx       = signed'({1'b0, bombTileX});
   assign ty       = signed'({1'b0, bombTileY});
   assign h_lo_raw = tx - ARM;
   assign h_hi_raw = tx + REACH;
   assign v_lo_raw = ty - ARM;
   assign v_hi_raw = ty + REACH;
   assign h_lo     = (h_lo_raw < XLO) ? XLO : h_lo_raw;
   assign h_hi     = (h_hi_raw > XHI) ? XHI : h_hi_raw;
   assign v_lo     = (v_lo_raw < YLO) ? YLO : v_lo_raw;
   assign v_hi     = (v_hi_raw > YHI) ? YHI : v_hi_raw;

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      tile_x_n = bombTileX;
      tile_y_n = bombTileY;
      box_n    = box_q;
      case (state)
         IDLE: begin
            if (bomb_drop && !drop_prev) begin
               tile_x_n = snap_x;
               tile_y_n = snap_y;
               cnt_n    = FUSE_LD;
               state_n  = FUSE;
            end
         end
         FUSE: begin
            if (cnt == 16'd0) begin
               state_n    = EXPLODE;
               cnt_n      = BLAST_LD;
               box_n.h_x  = 10'(h_lo);
               box_n.h_xs = 10'(h_hi - h_lo);
               box_n.h_y  = bombTileY;
               box_n.h_ys = SPAN;
               box_n.v_y  = 10'(v_lo);
               box_n.v_ys = 10'(v_hi - v_lo);
               box_n.v_x  = bombTileX;
               box_n.v_xs = SPAN;
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         EXPLODE: begin
            if (cnt == 16'd0) begin
               state_n = COOLDOWN;
               cnt_n   = COOL_LD;
               box_n   = '0;
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         COOLDOWN: begin
            if (cnt == 16'd0) state_n = IDLE;
            else              cnt_n   = cnt - 16'd1;
         end
         default: state_n = IDLE;
      endcase
   end

   // Status flags are registered from the next state so they align with it
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         cnt          <= '0;
         drop_prev    <= 1'b0;
         bombTileX    <= '0;
         bombTileY    <= '0;
         box_q        <= '0;
         bomb_visible <= 1'b0;
         exploding    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         drop_prev    <= bomb_drop;
         bombTileX    <= tile_x_n;
         bombTileY    <= tile_y_n;
         box_q        <= box_n;
         bomb_visible <= (state_n == FUSE);
         exploding    <= (state_n == EXPLODE);
         busy         <= (state_n != IDLE);
      end
   end

   assign hX  = box_q.h_x;
   assign hY  = box_q.h_y;
   assign hXS = box_q.h_xs;
   assign hYS = box_q.h_ys;
   assign vX  = box_q.v_x;
   assign vY  = box_q.v_y;
   assign vXS = box_q.v_xs;
   assign vYS = box_q.v_ys;

endmodule

// File: tb/tb_bomb_ctrl.sv
// Randomized scoreboard bench for bomb_ctrl: a timeline model predicts accepted
// drops, tile/box values and phase timing; a monitor checks what the DUT shows.
module tb_bomb_ctrl;

   localparam int TILE = 32, HALF_X = 10, HALF_Y = 13, RANGE = 2;
   localparam int FUSE = 120, BLAST = 30, COOL = 15;
   localparam int X_MIN = 32, X_MAX = 575, Y_MIN = 32, Y_MAX = 447;

   logic       frame_clk = 1'b0;
   logic       Reset = 1'b1;
   logic       bomb_drop = 1'b0;
   logic [9:0] userX = '0, userY = '0;
   logic [9:0] bombTileX, bombTileY, hX, hY, hXS, hYS, vX, vY, vXS, vYS;
   logic       bomb_visible, exploding, busy;

   bomb_ctrl dut (
      .frame_clk(frame_clk), .Reset(Reset), .bomb_drop(bomb_drop),
      .userX(userX), .userY(userY),
      .bombTileX(bombTileX), .bombTileY(bombTileY),
      .bomb_visible(bomb_visible), .exploding(exploding),
      .hX(hX), .hY(hY), .hXS(hXS), .hYS(hYS),
      .vX(vX), .vY(vY), .vXS(vXS), .vYS(vYS),
      .busy(busy)
   );

   always #5 frame_clk = ~frame_clk;

   int cyc = 0;
   always @(posedge frame_clk) cyc <= cyc + 1;

   typedef struct {int at; int tx; int ty;} fuse_t;
   typedef struct {
      int at; int fin;
      int hx, hy, hxs, hys, vx, vy, vxs, vys;
      bit chk_hit;
   } blast_t;

   fuse_t  fuse_q[$];
   blast_t blast_q[$];

   int total = 0, bad = 0;
   int m_prev = 0, m_free = 0, m_acc = -100000;
   bit in_blast = 0;
   int blast_end = 0;
   bit pv = 0, pe = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int max2(input int a, input int b); return (a > b) ? a : b; endfunction
   function automatic int min2(input int a, input int b); return (a < b) ? a : b; endfunction

   function automatic int outs_or();
      return int'(bombTileX | bombTileY | hX | hY | hXS | hYS | vX | vY | vXS | vYS)
             + int'(bomb_visible) + int'(exploding) + int'(busy);
   endfunction

   function automatic bit in_box(input int px, input int py, input int bx, input int by,
                                 input int bxs, input int bys);
      return (px > bx) && (px <= bx + bxs) && (py > by) && (py <= by + bys);
   endfunction

   function automatic int hits(input int px, input int py);
      return int'(in_box(px, py, int'(hX), int'(hY), int'(hXS), int'(hYS)) ||
                  in_box(px, py, int'(vX), int'(vY), int'(vXS), int'(vYS)));
   endfunction

   // One frame of stimulus; the model decides whether this edge starts a bomb
   task automatic step(input bit d, input int ux, input int uy, input bit chk);
      int k;
      fuse_t f;
      blast_t b;
      @(negedge frame_clk);
      bomb_drop = d;
      userX = 10'(ux);
      userY = 10'(uy);
      k = cyc + 1;
      if (d && m_prev == 0 && k >= m_free) begin
         f.at = k;
         f.tx = ((ux + HALF_X) / TILE) * TILE;
         f.ty = ((uy + HALF_Y) / TILE) * TILE;
         b.at  = k + FUSE;
         b.fin = k + FUSE + BLAST;
         b.hx  = max2(f.tx - RANGE * TILE, X_MIN);
         b.hxs = min2(f.tx + (RANGE + 1) * TILE - 1, X_MAX) - b.hx;
         b.hy  = f.ty;
         b.hys = TILE - 1;
         b.vy  = max2(f.ty - RANGE * TILE, Y_MIN);
         b.vys = min2(f.ty + (RANGE + 1) * TILE - 1, Y_MAX) - b.vy;
         b.vx  = f.tx;
         b.vxs = TILE - 1;
         b.chk_hit = chk;
         fuse_q.push_back(f);
         blast_q.push_back(b);
         m_acc  = k;
         m_free = k + FUSE + BLAST + COOL + 1;
      end
      m_prev = d;
   endtask

   task automatic idle_until(input int c);
      while (cyc < c) step(1'b0, 0, 0, 1'b0);
   endtask

   // Monitor: checks busy every frame and pops expectations on output events
   initial begin
      fuse_t f;
      blast_t b;
      forever begin
         @(negedge frame_clk);
         if (Reset) begin
            pv = 0; pe = 0; in_blast = 0;
            continue;
         end
         check("busy", int'(busy), int'(m_acc <= cyc && cyc < m_acc + FUSE + BLAST + COOL));
         if (bomb_visible && !pv) begin
            if (fuse_q.size() == 0) check("unexpected_fuse", 1, 0);
            else begin
               f = fuse_q.pop_front();
               check("fuse_start", cyc, f.at);
               check("tile_x", int'(bombTileX), f.tx);
               check("tile_y", int'(bombTileY), f.ty);
            end
         end
         if (exploding && !pe) begin
            if (blast_q.size() == 0) check("unexpected_blast", 1, 0);
            else begin
               b = blast_q.pop_front();
               check("blast_start", cyc, b.at);
               check("visible_off", int'(bomb_visible), 0);
               check("hX", int'(hX), b.hx);
               check("hXS", int'(hXS), b.hxs);
               check("hY", int'(hY), b.hy);
               check("hYS", int'(hYS), b.hys);
               check("vX", int'(vX), b.vx);
               check("vXS", int'(vXS), b.vxs);
               check("vY", int'(vY), b.vy);
               check("vYS", int'(vYS), b.vys);
               if (b.chk_hit) begin
                  check("hit_inside", hits(100, 196), 1);
                  check("hit_outside", hits(300, 196), 0);
               end
               in_blast = 1;
               blast_end = b.fin;
            end
         end
         if (!exploding && pe && in_blast) begin
            check("blast_end", cyc, blast_end);
            check("boxes_cleared", int'(hX | hY | hXS | hYS | vX | vY | vXS | vYS), 0);
            in_blast = 0;
         end
         pv = bomb_visible;
         pe = exploding;
      end
   end

   initial begin
      int k0;
      repeat (3) @(negedge frame_clk);
      check("reset_state", outs_or(), 0);
      #2 Reset = 1'b0;

      // Basic drop with collision probes during the blast
      step(1'b1, 100, 200, 1'b1);
      step(1'b0, 100, 200, 1'b0);
      idle_until(m_free + 2);

      // Right/bottom clamping
      step(1'b1, 540, 420, 1'b0);
      step(1'b0, 540, 420, 1'b0);
      idle_until(m_free + 2);

      // Held request: one bomb only
      repeat (200) step(1'b1, 250, 150, 1'b0);
      step(1'b0, 250, 150, 1'b0);
      idle_until(m_free + 2);

      // Edges during FUSE and COOLDOWN are ignored; held level through IDLE does not fire
      step(1'b1, 60, 60, 1'b0);
      k0 = m_acc;
      while (cyc + 1 < k0 + 50) step(1'b0, 60, 60, 1'b0);
      step(1'b1, 400, 300, 1'b0);
      while (cyc + 1 < k0 + FUSE + BLAST + 5) step(1'b0, 400, 300, 1'b0);
      while (cyc + 1 < k0 + FUSE + BLAST + COOL + 15) step(1'b1, 400, 300, 1'b0);
      step(1'b0, 400, 300, 1'b0);
      idle_until(cyc + 5);
      step(1'b1, 10, 5, 1'b0);
      step(1'b0, 10, 5, 1'b0);

      // Reset during EXPLODE aborts the blast
      while (cyc < m_acc + FUSE + 9) step(1'b0, 10, 5, 1'b0);
      #2 Reset = 1'b1;
      #1 check("reset_abort", outs_or(), 0);
      fuse_q.delete();
      blast_q.delete();
      m_prev = 0; m_free = 0; m_acc = -100000;
      repeat (3) @(negedge frame_clk);
      #2 Reset = 1'b0;
      step(1'b1, 300, 100, 1'b0);
      step(1'b0, 300, 100, 1'b0);
      idle_until(m_free + 2);

      // Random traffic
      repeat (3000) step($urandom_range(0, 3) == 0, int'($urandom_range(0, 600)),
                         int'($urandom_range(0, 470)), 1'b0);
      step(1'b0, 0, 0, 1'b0);
      idle_until(m_free + 3);

      check("fuse_q_drained", fuse_q.size(), 0);
      check("blast_q_drained", blast_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
